// File: rtl/param_data_memory.sv
// param_data_memory: multi-cycle word-addressed data memory with a counter-driven latency model.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   read, write       : access requests, held until busywait is seen low
//   address, writedata: word address and write data, captured when an access starts
//   readdata          : registered read data, updated only by completed reads
//   busywait          : access pending/in progress (combinational)
//   req_error         : one-cycle pulse after an edge that saw read and write both high in IDLE
//   rd_count, wr_count: saturating completed-access counters, present only with MEM_ACCESS_COUNT_EN
module param_data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  busywait,
    output logic                  req_error,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit LAT1 = (LATENCY == 1);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    op_q, op_d;
    logic [DATA_WIDTH-1:0]   readdata_q, readdata_d;
    logic                    req_error_q, req_error_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    one_req;
    logic                    do_access;
    logic                    acc_write;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;

    always_comb begin
        one_req = read ^ write;
        // With LATENCY=1 the access completes on the accepting edge, so live inputs are used.
        do_access = (state_q == IDLE) ? (one_req && LAT1)
                  : (state_q == BUSY) ? (cnt_q == 8'd1 || LAT1) : 1'b0;
        acc_write = (state_q == IDLE) ? write : op_q;
        acc_addr  = (state_q == IDLE) ? address : addr_q;
        acc_wdata = (state_q == IDLE) ? writedata : wdata_q;
        state_d = (state_q == IDLE) ? (one_req ? (LAT1 ? DONE : BUSY) : IDLE)
                : (state_q == BUSY) ? (do_access ? DONE : BUSY) : IDLE;
        cnt_d   = (state_q == IDLE && one_req) ? CNT_LOAD
                : (state_q == BUSY && !do_access) ? cnt_q - 8'd1 : cnt_q;
        addr_d  = (state_q == IDLE && one_req) ? address : addr_q;
        wdata_d = (state_q == IDLE && one_req) ? writedata : wdata_q;
        op_d    = (state_q == IDLE && one_req) ? write : op_q;
        readdata_d  = (do_access && !acc_write) ? mem_q[acc_addr] : readdata_q;
        req_error_d = (state_q == IDLE) && read && write;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= 1'b0;
            readdata_q  <= '0;
            req_error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            readdata_q  <= readdata_d;
            req_error_q <= req_error_d;
            if (do_access && acc_write) mem_q[acc_addr] <= acc_wdata;
        end
    end

    // Gated by reset so the cache sees the memory idle while reset is held.
    assign busywait  = !reset && (((state_q == IDLE) && one_req) || (state_q == BUSY));
    assign readdata  = readdata_q;
    assign req_error = req_error_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = (do_access && !acc_write && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
        wr_count_d = (do_access && acc_write && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: directed self-checking bench for param_data_memory.
module tb_param_data_memory;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        busywait, req_error;
    logic [15:0] rd_count, wr_count;
    logic        read1 = 1'b0, write1 = 1'b0;
    logic [5:0]  address1 = '0;
    logic [31:0] writedata1 = '0;
    logic [31:0] readdata1;
    logic        busywait1, req_error1;
    logic [15:0] rd_count1, wr_count1;
    int          checks = 0;
    int          failures = 0;
    int          n;

    param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(5)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait),
        .req_error(req_error), .rd_count(rd_count), .wr_count(wr_count)
    );

    param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .read(read1), .write(write1), .address(address1),
        .writedata(writedata1), .readdata(readdata1), .busywait(busywait1),
        .req_error(req_error1), .rd_count(rd_count1), .wr_count(wr_count1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [5:0] a,
                          input logic [31:0] d, input bit tamper, output int cycles);
        read = rd;
        write = wr;
        address = a;
        writedata = d;
        #1;
        cycles = 0;
        while (busywait && cycles < 20) begin
            cycles++;
            if (tamper && cycles == 2) begin
                address = 6'd3;
                writedata = 32'h0;
            end
            @(negedge clock);
        end
        read = 1'b0;
        write = 1'b0;
        @(negedge clock);
    endtask

    task automatic access1(input logic rd, input logic wr, input logic [5:0] a,
                           input logic [31:0] d, output int cycles);
        read1 = rd;
        write1 = wr;
        address1 = a;
        writedata1 = d;
        #1;
        cycles = 0;
        while (busywait1 && cycles < 20) begin
            cycles++;
            @(negedge clock);
        end
        read1 = 1'b0;
        write1 = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busywait", 32'(busywait), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_req_error", 32'(req_error), 32'd0);

        access(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, n);
        chk("rd5_busy_cycles", 32'(n), 32'd5);
        chk("rd5_data", readdata, 32'h0);

        access(1'b0, 1'b1, 6'd12, 32'hDEADBEEF, 1'b0, n);
        chk("wr12_busy_cycles", 32'(n), 32'd5);
        chk("wr12_readdata_kept", readdata, 32'h0);
        access(1'b1, 1'b0, 6'd12, 32'h0, 1'b0, n);
        chk("rd12_busy_cycles", 32'(n), 32'd5);
        chk("rd12_data", readdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 6'd11, 32'h0, 1'b0, n);
        chk("rd11_data", readdata, 32'h0);

        access(1'b0, 1'b1, 6'd7, 32'h12345678, 1'b1, n);
        chk("wr7_tamper_busy_cycles", 32'(n), 32'd5);
        access(1'b1, 1'b0, 6'd7, 32'h0, 1'b0, n);
        chk("rd7_data", readdata, 32'h12345678);

        read = 1'b1;
        write = 1'b1;
        #1;
        chk("err_busywait", 32'(busywait), 32'd0);
        @(negedge clock);
        chk("err_pulse1", 32'(req_error), 32'd1);
        chk("err_busywait2", 32'(busywait), 32'd0);
        @(negedge clock);
        chk("err_pulse2", 32'(req_error), 32'd1);
        read = 1'b0;
        write = 1'b0;
        @(negedge clock);
        chk("err_cleared", 32'(req_error), 32'd0);
        chk("err_readdata_kept", readdata, 32'h12345678);

        access(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, n);
        chk("rd3_untouched", readdata, 32'h0);
        access(1'b1, 1'b0, 6'd7, 32'h0, 1'b0, n);
        chk("rd7_after_err", readdata, 32'h12345678);

        address = 6'd2;
        writedata = 32'hA5A5A5A5;
        write = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busywait", 32'(busywait), 32'd0);
        chk("abort_readdata", readdata, 32'h0);
        write = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_idle_busywait", 32'(busywait), 32'd0);
        access(1'b1, 1'b0, 6'd2, 32'h0, 1'b0, n);
        chk("rd2_after_abort", readdata, 32'h0);
        access(1'b1, 1'b0, 6'd12, 32'h0, 1'b0, n);
        chk("rd12_cleared_by_reset", readdata, 32'h0);

        access1(1'b0, 1'b1, 6'd1, 32'h11111111, n);
        chk("l1_wr1_cycles", 32'(n), 32'd1);
        access1(1'b0, 1'b1, 6'd2, 32'h22222222, n);
        chk("l1_wr2_cycles", 32'(n), 32'd1);
        access1(1'b0, 1'b1, 6'd63, 32'hCAFEF00D, n);
        chk("l1_wr3_cycles", 32'(n), 32'd1);
        access1(1'b1, 1'b0, 6'd2, 32'h0, n);
        chk("l1_rd2_cycles", 32'(n), 32'd1);
        chk("l1_rd2_data", readdata1, 32'h22222222);
        access1(1'b1, 1'b0, 6'd63, 32'h0, n);
        chk("l1_rd63_data", readdata1, 32'hCAFEF00D);
`ifdef MEM_ACCESS_COUNT_EN
        chk("l1_wr_count", 32'(wr_count1), 32'd3);
        chk("l1_rd_count", 32'(rd_count1), 32'd2);
`else
        chk("l1_wr_count", 32'(wr_count1), 32'd0);
        chk("l1_rd_count", 32'(rd_count1), 32'd0);
        chk("wr_count_off", 32'(wr_count), 32'd0);
        chk("rd_count_off", 32'(rd_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
